if_fetch_stage: RTL and testbench

//  Instruction fetch stage: owns the PC, issues reads to a 1-cycle-latency synchronous

---
 rtl/if_fetch_stage_if.sv | 15 +
 rtl/if_fetch_stage.sv | 152 +++++++++++++++
 tb/tb_if_fetch_stage.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory read bus between the fetch stage (master) and a
// synchronous 1-cycle-latency instruction memory (slave).
//
// Handshake: rd_en is a request strobe with no backpressure. The memory must
// accept every cycle in which rd_en=1 and present rdata for addr on the
// following cycle. The master only consumes rdata the cycle after its own
// rd_en, so rdata is don't-care at all other times.
interface if_fetch_stage_if;
  logic        rd_en;
  logic [31:0] addr;
  logic [31:0] rdata;

  modport master (output rd_en, output addr, input rdata);
  modport slave  (input rd_en, input addr, output rdata);
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: owns the PC, issues one read per cycle to a
// 1-cycle-latency instruction memory and buffers returned words in a 2-entry
// skid FIFO whose head feeds the IF/DE register.
// Optional feature macro: FETCH_PERF_EN adds saturating fetch/kill counters.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [31:0]      branch_target,
  if_fetch_stage_if.master imem,
  output logic [31:0]      inst_out,
  output logic [31:0]      pc_out,
  output logic             inst_valid,
  output logic             state_dbg
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]      perf_fetch_cnt,
  output logic [15:0]      perf_kill_cnt
`endif
);

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] pc;
  logic [31:0] pend_pc;
  logic        inflight;
  logic [1:0]  count;
  logic [31:0] fifo_inst [2];
  logic [31:0] fifo_pc   [2];

  logic        pop;
  logic        push;
  logic        issue;
  logic [1:0]  occ_after_pop;
  logic [1:0]  wr_idx;
  logic        unused_tgt_lsb;

  // Target low bits are forced to zero, so they never reach any state.
  assign unused_tgt_lsb = ^branch_target[1:0];

  assign state_dbg = state;

  // Next state and handshake decisions. Issue only when the word it fetches
  // is guaranteed a FIFO slot, counting the in-flight read and this cycle's pop.
  always_comb begin
    state_next    = state;
    pop           = 1'b0;
    push          = 1'b0;
    issue         = 1'b0;
    occ_after_pop = 2'd0;
    wr_idx        = 2'd0;
    if (state == BOOT) begin
      state_next = RUN;
    end
    pop           = (count != 2'd0) && !stall;
    push          = inflight && !branch_taken;
    occ_after_pop = count + {1'b0, inflight} - {1'b0, pop};
    wr_idx        = count - {1'b0, pop};
    issue         = (state == RUN) && !branch_taken && (occ_after_pop < 2'd2);
  end

  // Memory request and FIFO-head outputs; outputs come only from registers.
  always_comb begin
    imem.rd_en = issue;
    imem.addr  = pc;
    inst_valid = (count != 2'd0);
    inst_out   = NOP_INST;
    pc_out     = 32'd0;
    if (count != 2'd0) begin
      inst_out = fifo_inst[0];
      pc_out   = fifo_pc[0];
    end
  end

  // Control state: PC, FSM, FIFO occupancy and the in-flight read flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= BOOT;
      pc       <= RESET_PC;
      pend_pc  <= 32'd0;
      inflight <= 1'b0;
      count    <= 2'd0;
    end else begin
      state <= state_next;
      if (branch_taken) begin
        count    <= 2'd0;
        inflight <= 1'b0;
        pc       <= {branch_target[31:2], 2'b00};
      end else begin
        count    <= count + {1'b0, push} - {1'b0, pop};
        inflight <= issue;
        if (issue) begin
          pc      <= pc + 32'd4;
          pend_pc <= pc;
        end
      end
    end
  end

  // FIFO storage: pop shifts entry 1 to the head; a push lands in the first
  // free slot after the pop, so the later write wins when both hit slot 0.
  always_ff @(posedge clk) begin
    if (pop) begin
      fifo_inst[0] <= fifo_inst[1];
      fifo_pc[0]   <= fifo_pc[1];
    end
    if (push) begin
      fifo_inst[wr_idx[0]] <= imem.rdata;
      fifo_pc[wr_idx[0]]   <= pend_pc;
    end
  end

  // A returning word must always find a free slot.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      assert (wr_idx < 2'd2);
    end
  end

`ifdef FETCH_PERF_EN
  logic [1:0]  kill_add;
  logic [16:0] kill_sum;

  assign kill_add = count + {1'b0, inflight};
  assign kill_sum = {1'b0, perf_kill_cnt} + {15'd0, kill_add};

  // Saturating counters: words handed downstream and words thrown away by branches.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_fetch_cnt <= 32'd0;
      perf_kill_cnt  <= 16'd0;
    end else begin
      if (pop && (perf_fetch_cnt != 32'hFFFF_FFFF)) begin
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      end
      if (branch_taken) begin
        perf_kill_cnt <= kill_sum[16] ? 16'hFFFF : kill_sum[15:0];
      end
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: a queue-based model of the fetch stream, random
// stall/branch/reset stimulus, and directed literal checks of the key scenarios.
`timescale 1ns/1ps
module tb_if_fetch_stage;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] TAG   = 32'hA000_0000;
  localparam logic [31:0] RPC_B = 32'hFFFF_FFF8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;

  if_fetch_stage_if imem_a ();
  if_fetch_stage_if imem_b ();

  logic [31:0] inst_out_a, pc_out_a, inst_out_b, pc_out_b;
  logic        inst_valid_a, inst_valid_b, state_a, state_b;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_a, perf_fetch_b;
  logic [15:0] perf_kill_a, perf_kill_b;
`endif

  if_fetch_stage u_dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem(imem_a), .inst_out(inst_out_a),
    .pc_out(pc_out_a), .inst_valid(inst_valid_a), .state_dbg(state_a)
`ifdef FETCH_PERF_EN
    , .perf_fetch_cnt(perf_fetch_a), .perf_kill_cnt(perf_kill_a)
`endif
  );

  if_fetch_stage #(.RESET_PC(RPC_B)) u_dut_wrap (
    .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem(imem_b), .inst_out(inst_out_b),
    .pc_out(pc_out_b), .inst_valid(inst_valid_b), .state_dbg(state_b)
`ifdef FETCH_PERF_EN
    , .perf_fetch_cnt(perf_fetch_b), .perf_kill_cnt(perf_kill_b)
`endif
  );

  // Instruction memories: word at byte address a is a | 0xA000_0000.
  always @(posedge clk) begin
    if (imem_a.rd_en) imem_a.rdata <= imem_a.addr | TAG;
    if (imem_b.rd_en) imem_b.rdata <= imem_b.addr | TAG;
  end

  // ---------------- scoreboard / model ----------------
  int n_tests = 0;
  int n_fail  = 0;
  bit model_on = 1'b0;

  logic [31:0] exp_q[$];   // PCs held in the skid buffer, head first
  logic [31:0] req_q[$];   // PC of the read issued last cycle
  logic [31:0] m_pc;
  bit          m_boot;
  int          m_fetch;
  int          m_kill;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_pop();
    return (exp_q.size() != 0) && !stall;
  endfunction

  function automatic bit m_issue();
    int occ;
    occ = exp_q.size() + req_q.size() - (m_pop() ? 1 : 0);
    return !m_boot && !branch_taken && (occ < 2);
  endfunction

  task automatic compare();
    chk("rd_en", {31'd0, imem_a.rd_en}, {31'd0, m_issue()});
    chk("addr", imem_a.addr, m_pc);
    chk("state", {31'd0, state_a}, {31'd0, !m_boot});
    chk("valid", {31'd0, inst_valid_a}, {31'd0, exp_q.size() != 0});
    if (!branch_taken) begin
      chk("pc_out", pc_out_a, (exp_q.size() != 0) ? exp_q[0] : 32'd0);
      chk("inst_out", inst_out_a, (exp_q.size() != 0) ? (exp_q[0] | TAG) : NOP);
    end
`ifdef FETCH_PERF_EN
    chk("perf_fetch", perf_fetch_a, m_fetch);
    chk("perf_kill", {16'd0, perf_kill_a}, m_kill);
`endif
  endtask

  task automatic update();
    bit p, iss;
    if (!rst_n) begin
      m_pc = 32'd0; m_boot = 1'b1; m_fetch = 0; m_kill = 0;
      exp_q.delete(); req_q.delete();
    end else begin
      p = m_pop(); iss = m_issue();
      if (p) m_fetch++;
      if (branch_taken) begin
        m_kill += exp_q.size() + req_q.size();
        exp_q.delete(); req_q.delete();
        m_pc = {branch_target[31:2], 2'b00};
      end else begin
        if (p) void'(exp_q.pop_front());
        if (req_q.size() != 0) exp_q.push_back(req_q.pop_front());
        if (iss) begin
          req_q.push_back(m_pc);
          m_pc = m_pc + 32'd4;
        end
      end
      m_boot = 1'b0;
    end
  endtask

  // ---------------- driver ----------------
  task automatic step();
    #1;
    if (model_on) compare();
    @(posedge clk);
    update();
    @(negedge clk);
  endtask

  task automatic random_run(input int cycles, input bit with_reset);
    for (int i = 0; i < cycles; i++) begin
      stall         = ($urandom_range(0, 3) == 0);
      branch_taken  = ($urandom_range(0, 15) == 0);
      branch_target = $urandom;
      rst_n         = with_reset ? ($urandom_range(0, 99) != 0) : 1'b1;
      step();
    end
    stall = 1'b0; branch_taken = 1'b0; rst_n = 1'b1;
  endtask

  initial begin
    int waited;
    bit found;
    logic [31:0] exp_pc;
    rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'd0;
    @(negedge clk);
    step();
    step();
    model_on = 1'b1;

    // reset state
    #1;
    chk("rst_valid", {31'd0, inst_valid_a}, 32'd0);
    chk("rst_inst", inst_out_a, NOP);
    chk("rst_pc", pc_out_a, 32'd0);
    chk("rst_rd_en", {31'd0, imem_a.rd_en}, 32'd0);
    chk("rst_addr", imem_a.addr, 32'd0);
    chk("rst_addr_wrap", imem_b.addr, RPC_B);
    chk("rst_state", {31'd0, state_a}, 32'd0);

    // reset release: first word after the 3rd edge, then back-to-back
    rst_n = 1'b1;
    step();
    chk("boot_to_run", {31'd0, state_a}, 32'd1);
    step();
    chk("not_yet_valid", {31'd0, inst_valid_a}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      exp_pc = 32'd4 * k;
      chk("t1_pc", pc_out_a, exp_pc);
      chk("t1_inst", inst_out_a, exp_pc | TAG);
      exp_pc = RPC_B + 32'd4 * k;
      chk("t5_wrap_pc", pc_out_b, exp_pc);
    end
    chk("t5_wrap_inst", inst_out_b, TAG);

    // stall at pc_out=8: held, fills, no reads while full, then 8,C,10
    stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t2_hold", pc_out_a, 32'h8);
      if (k >= 1) chk("t2_no_read", {31'd0, imem_a.rd_en}, 32'd0);
      step();
    end
    stall = 1'b0;
    for (int k = 0; k < 3; k++) begin
      exp_pc = 32'h8 + 32'd4 * k;
      chk("t2_resume", pc_out_a, exp_pc);
      step();
    end

    // branch to 0x102 mid-stream: next valid word is 0x100
    branch_taken = 1'b1; branch_target = 32'h0000_0102;
    step();
    branch_taken = 1'b0;
    #1;
    chk("t3_issue_tgt", imem_a.addr, 32'h100);
    chk("t3_issue_en", {31'd0, imem_a.rd_en}, 32'd1);
    found = 1'b0; waited = 0;
    while (!found && waited < 6) begin
      if (inst_valid_a) found = 1'b1;
      else begin step(); waited++; end
    end
    chk("t3_timeout", {31'd0, found}, 32'd1);
    chk("t3_first_pc", pc_out_a, 32'h100);

    random_run(200, 1'b0);

    // one-cycle reset mid-stream
    for (int k = 0; k < 4; k++) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    chk("t6_valid", {31'd0, inst_valid_a}, 32'd0);
    chk("t6_addr", imem_a.addr, 32'd0);
`ifdef FETCH_PERF_EN
    chk("t6_fetch_zero", perf_fetch_a, 32'd0);
    chk("t6_kill_zero", {16'd0, perf_kill_a}, 32'd0);
`endif
    for (int k = 0; k < 3; k++) step();
    chk("t6_restart", pc_out_a, 32'd0);

    // fill under stall, then branch+stall together
    stall = 1'b1;
    for (int k = 0; k < 3; k++) step();
    chk("t4_full_noread", {31'd0, imem_a.rd_en}, 32'd0);
    branch_taken = 1'b1; branch_target = 32'h0000_0100;
    step();
    branch_taken = 1'b0;
    #1;
    chk("t4_flushed", {31'd0, inst_valid_a}, 32'd0);
    chk("t4_addr", imem_a.addr, 32'h100);
    chk("t4_rd_en", {31'd0, imem_a.rd_en}, 32'd1);
`ifdef FETCH_PERF_EN
    chk("t4_kill_cnt", {16'd0, perf_kill_a}, 32'd2);
`endif
    stall = 1'b0;

    random_run(400, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
